// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory path: word width, line geometry and
// the coalescer state encoding.
package gpu_mem_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned DEF_LINE_WORDS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Byte-address bits covered by one line: word index bits plus the byte lane.
    function automatic int unsigned line_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/mem_coalesce_pick.sv
// Combinational line selection for one replay beat: picks the leader thread,
// gathers all remaining threads on the leader's line and merges their store data.
module mem_coalesce_pick
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    localparam int unsigned LB         = line_bits(LINE_WORDS),
    localparam int unsigned OW         = LB - 2
) (
    input  logic [NUM_THREADS-1:0]        rem,
    input  logic [NUM_THREADS*WORD_W-1:0] eff_addr,
    input  logic [NUM_THREADS*WORD_W-1:0] wdata,
    output logic [WORD_W-LB-1:0]          line_addr,
    output logic [NUM_THREADS-1:0]        thread_mask,
    output logic [LINE_WORDS-1:0]         write_mask,
    output logic [LINE_WORDS*WORD_W-1:0]  line_data
);

    logic found;

    // Leader = lowest remaining thread; the write mask doubles as a "word
    // already claimed" flag so the ascending scan gives lowest-index priority.
    always_comb begin
        found       = 1'b0;
        line_addr   = eff_addr[WORD_W-1:LB];
        thread_mask = '0;
        write_mask  = '0;
        line_data   = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (rem[i] && !found) begin
                found     = 1'b1;
                line_addr = eff_addr[i*WORD_W+LB +: WORD_W-LB];
            end
        end
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            thread_mask[i] = rem[i] && (eff_addr[i*WORD_W+LB +: WORD_W-LB] == line_addr);
        end
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            for (int unsigned w = 0; w < LINE_WORDS; w++) begin
                if (thread_mask[i] && !write_mask[w] &&
                    (eff_addr[i*WORD_W+2 +: OW] == OW'(w))) begin
                    write_mask[w]               = 1'b1;
                    line_data[w*WORD_W +: WORD_W] = wdata[i*WORD_W +: WORD_W];
                end
            end
        end
    end

endmodule

// File: rtl/mem_coalesce_replay.sv
// Warp memory request coalescer: holds one warp request and replays it as a
// sequence of cache-line beats until every active thread has been served.
module mem_coalesce_replay
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned LINE_WORDS  = 8,
    parameter int unsigned WARP_ID_W   = 3,
    localparam int unsigned LB         = line_bits(LINE_WORDS),
    localparam int unsigned OW         = LB - 2,
    localparam int unsigned PW         = $clog2(NUM_THREADS + 1)
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic                          shared_global_bar,
    input  logic [WARP_ID_W-1:0]          warp_ID,
    input  logic [1:0]                    scb_ID,
    input  logic [4:0]                    reg_addr,
    input  logic [31:0]                   Instr,
    input  logic [NUM_THREADS-1:0]        PAM,
    input  logic [NUM_THREADS*WORD_W-1:0] eff_addr,
    input  logic [NUM_THREADS*WORD_W-1:0] write_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          MemRead_o,
    output logic                          MemWrite_o,
    output logic                          shared_global_bar_o,
    output logic [WORD_W-LB-1:0]          mem_addr_o,
    output logic [NUM_THREADS-1:0]        thread_mask_o,
    output logic [LINE_WORDS-1:0]         mem_write_mask_o,
    output logic [NUM_THREADS*OW-1:0]     word_offset_o,
    output logic [LINE_WORDS*WORD_W-1:0]  write_data_o,
    output logic                          last_o,
    output logic [PW-1:0]                 pass_cnt_o,
    output logic [WARP_ID_W-1:0]          warp_ID_o,
    output logic [1:0]                    scb_ID_o,
    output logic [4:0]                    reg_addr_o,
    output logic [31:0]                   Instr_o
);

    state_t                        state_q, state_d;
    logic [NUM_THREADS-1:0]        rem_q, rem_d;
    logic [PW-1:0]                 pass_q, pass_d;
    logic                          rd_q, rd_d, wr_q, wr_d, sgb_q, sgb_d;
    logic [WARP_ID_W-1:0]          warp_q, warp_d;
    logic [1:0]                    scb_q, scb_d;
    logic [4:0]                    reg_q, reg_d;
    logic [31:0]                   instr_q, instr_d;
    logic [NUM_THREADS*WORD_W-1:0] addr_q, addr_d, data_q, data_d;

    logic accept, fire;

    mem_coalesce_pick #(
        .NUM_THREADS (NUM_THREADS),
        .LINE_WORDS  (LINE_WORDS)
    ) u_pick (
        .rem         (rem_q),
        .eff_addr    (addr_q),
        .wdata       (data_q),
        .line_addr   (mem_addr_o),
        .thread_mask (thread_mask_o),
        .write_mask  (mem_write_mask_o),
        .line_data   (write_data_o)
    );

    // Beat handshake decode and held-field outputs; a read+write request is a write.
    always_comb begin
        out_valid           = (state_q == ISSUE);
        last_o              = out_valid && ((rem_q & ~thread_mask_o) == '0);
        fire                = out_valid && out_ready;
        req_ready           = (state_q == IDLE) || (fire && last_o);
        accept              = req_valid && req_ready;
        MemRead_o           = rd_q && !wr_q;
        MemWrite_o          = wr_q;
        shared_global_bar_o = sgb_q;
        warp_ID_o           = warp_q;
        scb_ID_o            = scb_q;
        reg_addr_o          = reg_q;
        Instr_o             = instr_q;
        pass_cnt_o          = pass_q;
        word_offset_o       = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            word_offset_o[i*OW +: OW] = addr_q[i*WORD_W+2 +: OW];
        end
    end

    // Next state: retire served threads on each beat; a new accept overrides
    // the retirement so the last beat and the next capture share one edge.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pass_d  = pass_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        sgb_d   = sgb_q;
        warp_d  = warp_q;
        scb_d   = scb_q;
        reg_d   = reg_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fire) begin
            rem_d  = rem_q & ~thread_mask_o;
            pass_d = pass_q + PW'(1);
            if (last_o) begin
                state_d = IDLE;
            end
        end
        if (accept) begin
            rem_d   = PAM;
            pass_d  = '0;
            rd_d    = MemRead;
            wr_d    = MemWrite;
            sgb_d   = shared_global_bar;
            warp_d  = warp_ID;
            scb_d   = scb_ID;
            reg_d   = reg_addr;
            instr_d = Instr;
            addr_d  = eff_addr;
            data_d  = write_data;
            state_d = (MemRead || MemWrite) ? ISSUE : IDLE;
        end
    end

    // State and holding registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pass_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            sgb_q   <= 1'b0;
            warp_q  <= '0;
            scb_q   <= '0;
            reg_q   <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pass_q  <= pass_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            sgb_q   <= sgb_d;
            warp_q  <= warp_d;
            scb_q   <= scb_d;
            reg_q   <= reg_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule
